// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch constants, FSM state codes and target alignment helper.
package inst_fetch_pkg;
    localparam int          INST_ADDR_W  = 32;
    localparam int          INST_W       = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0;
    localparam logic [31:0] NOP_INST     = 32'h0;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [1:0]  S_IDLE       = 2'd0;
    localparam logic [1:0]  S_RUN        = 2'd1;
    localparam logic [1:0]  S_HOLD       = 2'd2;

    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: ROM fetch bus plus the IF/ID register outputs toward decode.
interface inst_fetch_if;
    import inst_fetch_pkg::*;
    logic                   rom_ce;
    logic [INST_ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0]      rom_inst;
    logic [INST_ADDR_W-1:0] id_pc;
    logic [INST_W-1:0]      id_inst;
    logic                   id_valid;
    logic                   id_misalign;
    modport master (output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_misalign, input rom_inst);
    modport slave  (input rom_ce, rom_addr, id_pc, id_inst, id_valid, id_misalign, output rom_inst);
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch FSM, PC, pending-branch register and redirect alignment.
// FETCH_ALIGN_CHECK_EN tags fetches from misaligned redirect targets via pc_mis.
module fetch_pc_gen
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] pc,
    output logic        pc_mis
);
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, tgt_a;
    logic        pend_v_q, pend_v_d, idle;

    always_comb begin
        idle       = state_q == S_IDLE;
        tgt_a      = align_word(branch_target);
        state_d    = idle ? S_RUN : (stall_if ? S_HOLD : S_RUN);
        pc_d       = idle ? RESET_PC : stall_if ? pc_q : branch_flag ? tgt_a :
                     pend_v_q ? pend_tgt_q : pc_q + 32'(PC_STEP);
        // A redirect seen during a stall is parked; the newest one wins.
        pend_v_d   = !flush && !idle && stall_if && (pend_v_q || branch_flag);
        pend_tgt_d = (stall_if && branch_flag) ? tgt_a : pend_tgt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= ZERO_WORD;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign rom_ce = idle ? CHIP_DISABLE : CHIP_ENABLE;
    assign pc     = pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis_q, mis_d, pend_mis_q, pend_mis_d, tgt_mis;

    always_comb begin
        tgt_mis    = |branch_target[1:0];
        mis_d      = idle ? 1'b0 : stall_if ? mis_q : branch_flag ? tgt_mis :
                     pend_v_q ? pend_mis_q : 1'b0;
        pend_mis_d = (stall_if && branch_flag) ? tgt_mis : pend_mis_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q      <= 1'b0;
            pend_mis_q <= 1'b0;
        end else begin
            mis_q      <= mis_d;
            pend_mis_q <= pend_mis_d;
        end
    end

    assign pc_mis = mis_q;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^branch_target[1:0];
    assign pc_mis         = 1'b0;
`endif
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage driving the ROM and owning the IF/ID register.
// FETCH_ALIGN_CHECK_EN enables the id_misalign tag on misaligned redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    inst_fetch_if.master      bus
);
    logic [31:0] pc, id_pc_q, id_pc_d, id_inst_q, id_inst_d;
    logic        rom_ce, pc_mis, id_valid_q, id_valid_d, id_mis_q, id_mis_d, hold, kill;

    fetch_pc_gen #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .flush         (flush),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .pc            (pc),
        .pc_mis        (pc_mis)
    );

    always_comb begin
        hold       = stall_if && stall_id;
        kill       = flush || (stall_if && !stall_id);
        id_pc_d    = flush ? ZERO_WORD : stall_if ? id_pc_q : pc;
        id_inst_d  = kill ? NOP_INST : hold ? id_inst_q : bus.rom_inst;
        id_valid_d = kill ? 1'b0 : hold ? id_valid_q : rom_ce;
        id_mis_d   = kill ? 1'b0 : hold ? id_mis_q : pc_mis;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= ZERO_WORD;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_mis_q   <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_mis_q   <= id_mis_d;
        end
    end

    assign bus.rom_ce      = rom_ce;
    assign bus.rom_addr    = pc;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_misalign = id_mis_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch; expected IF/ID contents are queued as stimulus is driven.
module tb_inst_fetch;
    typedef struct packed {
        logic        v;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, flush, branch_flag;
    logic [31:0] branch_target;
    logic        exp_mis;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        last;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush         (flush),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .bus           (bus)
    );

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign bus.rom_inst = rom_f(bus.rom_addr);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rom_ce"}, 32'(bus.rom_ce), 0);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_id_pc"}, bus.id_pc, 0);
        check({tag, "_id_inst"}, bus.id_inst, 0);
        check({tag, "_id_valid"}, 32'(bus.id_valid), 0);
        check({tag, "_id_mis"}, 32'(bus.id_misalign), 0);
    endtask

    task automatic release_rst();
        exp_t e;
        rst = 1'b0;
        e = '{v: 1'b0, chk_pc: 1'b1, pc: 32'h0, inst: rom_f(32'h0), mis: 1'b0};
        sb.push_back(e);
        last = e;
    endtask

    task automatic step(input logic [31:0] a, input logic si, input logic sd, input logic fl,
                        input logic br, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        check("sb_depth", 32'(sb.size()), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("id_valid", 32'(bus.id_valid), 32'(e.v));
            if (e.chk_pc) check("id_pc", bus.id_pc, e.pc);
            check("id_inst", bus.id_inst, e.inst);
            check("id_mis", 32'(bus.id_misalign), 32'(e.mis));
        end
        check("rom_ce", 32'(bus.rom_ce), 1);
        check("rom_addr", bus.rom_addr, a);
        stall_if = si; stall_id = sd; flush = fl; branch_flag = br; branch_target = tgt;
        if (fl) e = '{v: 1'b0, chk_pc: 1'b1, pc: 32'h0, inst: 32'h0, mis: 1'b0};
        else if (si && !sd) e = '{v: 1'b0, chk_pc: 1'b0, pc: 32'h0, inst: 32'h0, mis: 1'b0};
        else if (si) e = last;
        else e = '{v: 1'b1, chk_pc: 1'b1, pc: a, inst: rom_f(a), mis: exp_mis};
        sb.push_back(e);
        last = e;
        exp_mis = 1'b0;
    endtask

    task automatic run(input logic [31:0] a);
        step(a, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
        branch_flag = 1'b0; branch_target = 32'h0; exp_mis = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        release_rst();
        run(32'h0);
        run(32'h4);
        run(32'h8);
        run(32'hC);
        step(32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        run(32'h40);
        run(32'h44);
        step(32'h48, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8);
        step(32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        step(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(32'h8);
        run(32'h80);
        step(32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'h88, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        step(32'h88, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        run(32'h88);
        run(32'h8C);
        step(32'h90, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        step(32'h90, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
        run(32'h90);
        run(32'h20);
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        sb.delete();
        @(negedge clk);
        check_reset("rst_hold");
        release_rst();
        run(32'h0);
        step(32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        exp_mis = MIS_EXP;
        run(32'hFFFF_FFFC);
        run(32'h0);
        run(32'h4);
        run(32'h8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
